// File: rtl/eng_p_queue.sv
// rtl/eng_p_queue.sv - ENG_P result receiver: clause FIFO, dedup implication FIFO, conflict latch
//
// Receives per-clause results from the BCP processing element. Surviving
// pruned clauses go to a first-word-fall-through clause FIFO. Implied
// literals are deduplicated against the implication FIFO before they are
// enqueued toward the unit-clause queue. Conflicts are latched until the
// controller clears them after backtrack.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ENG_P_push        PE result valid
//   pr_clause         pruned clause, slot i at [i*LIT_W +: LIT_W]
//   imply, imply_idx  unit implication and its signed literal
//   done, conflict    clause satisfied / falsified
//   ENG_P_FULL        backpressure to the PE
//   cq_pop            consume the clause FIFO head
//   cq_empty          clause FIFO empty
//   cq_clause         clause FIFO head, zero when empty
//   cq_count          clause FIFO occupancy
//   uc_valid, uc_lit  implication FIFO head, literal zero when empty
//   uc_ready          unit-clause queue accepts uc_lit
//   conflict_flag     sticky conflict indication
//   conflict_clr      clear flag and counter, flush both FIFOs
//   sat_cnt           saturating satisfied-clause count

module eng_p_queue #(
   parameter int CLA_LENGTH = 3,
   parameter int LIT_W      = 8,
   parameter int CQ_DEPTH   = 8,
   parameter int IQ_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ENG_P_push,
   input  logic [CLA_LENGTH*LIT_W-1:0]    pr_clause,
   input  logic                           imply,
   input  logic signed [LIT_W-1:0]        imply_idx,
   input  logic                           done,
   input  logic                           conflict,
   output logic                           ENG_P_FULL,
   input  logic                           cq_pop,
   output logic                           cq_empty,
   output logic [CLA_LENGTH*LIT_W-1:0]    cq_clause,
   output logic [$clog2(CQ_DEPTH):0]      cq_count,
   output logic                           uc_valid,
   output logic [LIT_W-1:0]               uc_lit,
   input  logic                           uc_ready,
   output logic                           conflict_flag,
   input  logic                           conflict_clr,
   output logic [15:0]                    sat_cnt
);

   localparam int CW    = CLA_LENGTH * LIT_W;
   localparam int CQ_AW = $clog2(CQ_DEPTH);
   localparam int IQ_AW = $clog2(IQ_DEPTH);
   localparam logic [CQ_AW:0] LP_CQ_FULL = (CQ_AW+1)'(CQ_DEPTH);
   localparam logic [IQ_AW:0] LP_IQ_FULL = (IQ_AW+1)'(IQ_DEPTH);

   // clause FIFO state
   logic [CW-1:0]    r_cq_mem [CQ_DEPTH];
   logic [CQ_AW-1:0] r_cq_wp;
   logic [CQ_AW-1:0] r_cq_rp;
   logic [CQ_AW:0]   r_cq_cnt;

   // implication FIFO state
   logic [LIT_W-1:0] r_iq_mem [IQ_DEPTH];
   logic [IQ_AW-1:0] r_iq_wp;
   logic [IQ_AW-1:0] r_iq_rp;
   logic [IQ_AW:0]   r_iq_cnt;

   logic             r_conflict;
   logic [15:0]      r_sat_cnt;

   logic             w_full;
   logic             w_acc;
   logic             w_is_cf;
   logic             w_is_done;
   logic             w_is_imp;
   logic             w_is_plain;
   logic             w_imp_nz;
   logic [LIT_W-1:0] w_neg_idx;
   logic [IQ_DEPTH-1:0] w_iq_vld;
   logic [IQ_DEPTH-1:0] w_dup;
   logic [IQ_DEPTH-1:0] w_neg;
   logic             w_imp_neg;
   logic             w_iq_wr;
   logic             w_iq_rd;
   logic             w_cq_wr;
   logic             w_cq_rd;

   // Backpressure comes from registered occupancies only, so the PE never
   // sees a combinational path from its own push inputs.
   assign w_full = (r_cq_cnt == LP_CQ_FULL) || (r_iq_cnt == LP_IQ_FULL);
   assign w_acc  = ENG_P_push && !w_full;

   // Result classification, highest priority first.
   assign w_is_cf    = w_acc && conflict;
   assign w_is_done  = w_acc && !conflict && done;
   assign w_is_imp   = w_acc && !conflict && !done && imply;
   assign w_is_plain = w_acc && !conflict && !done && !imply;

   assign w_imp_nz  = |imply_idx;
   assign w_neg_idx = ~imply_idx + 1'b1;

   // An entry is live if its distance from the read pointer is below the
   // start-of-cycle count; an entry being dequeued this cycle still counts.
   for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_iq_cmp
      logic [IQ_AW-1:0] w_off;
      assign w_off       = IQ_AW'(g) - r_iq_rp;
      assign w_iq_vld[g] = ({1'b0, w_off} < r_iq_cnt);
      assign w_dup[g]    = w_iq_vld[g] && (r_iq_mem[g] == imply_idx);
      assign w_neg[g]    = w_iq_vld[g] && (r_iq_mem[g] == w_neg_idx);
   end

   // Duplicate detection wins over negation so a literal already queued is
   // never reported as contradicting itself.
   assign w_imp_neg = w_is_imp && w_imp_nz && !(|w_dup) && (|w_neg);
   assign w_iq_wr   = w_is_imp && w_imp_nz && !(|w_dup) && !(|w_neg);
   assign w_iq_rd   = uc_ready && (|r_iq_cnt);

   assign w_cq_wr = w_is_plain;
   assign w_cq_rd = cq_pop && (|r_cq_cnt);

   // Storage arrays carry no reset; validity is tracked by pointers/counts.
   always_ff @(posedge clk) begin
      if (w_cq_wr && !conflict_clr) begin
         r_cq_mem[r_cq_wp] <= pr_clause;
      end
      if (w_iq_wr && !conflict_clr) begin
         r_iq_mem[r_iq_wp] <= imply_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cq_wp    <= '0;
         r_cq_rp    <= '0;
         r_cq_cnt   <= '0;
         r_iq_wp    <= '0;
         r_iq_rp    <= '0;
         r_iq_cnt   <= '0;
         r_conflict <= 1'b0;
         r_sat_cnt  <= '0;
      end else if (conflict_clr) begin
         // Clear overrides any same-cycle push or pop.
         r_cq_wp    <= '0;
         r_cq_rp    <= '0;
         r_cq_cnt   <= '0;
         r_iq_wp    <= '0;
         r_iq_rp    <= '0;
         r_iq_cnt   <= '0;
         r_conflict <= 1'b0;
         r_sat_cnt  <= '0;
      end else begin
         if (w_cq_wr) begin
            r_cq_wp <= r_cq_wp + 1'b1;
         end
         if (w_cq_rd) begin
            r_cq_rp <= r_cq_rp + 1'b1;
         end
         case ({w_cq_wr, w_cq_rd})
            2'b10:   r_cq_cnt <= r_cq_cnt + 1'b1;
            2'b01:   r_cq_cnt <= r_cq_cnt - 1'b1;
            default: r_cq_cnt <= r_cq_cnt;
         endcase

         if (w_iq_wr) begin
            r_iq_wp <= r_iq_wp + 1'b1;
         end
         if (w_iq_rd) begin
            r_iq_rp <= r_iq_rp + 1'b1;
         end
         case ({w_iq_wr, w_iq_rd})
            2'b10:   r_iq_cnt <= r_iq_cnt + 1'b1;
            2'b01:   r_iq_cnt <= r_iq_cnt - 1'b1;
            default: r_iq_cnt <= r_iq_cnt;
         endcase

         if (w_is_cf || w_imp_neg) begin
            r_conflict <= 1'b1;
         end

         if (w_is_done && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
         end
      end
   end

   assign ENG_P_FULL    = w_full;
   assign cq_empty      = ~(|r_cq_cnt);
   assign cq_clause     = cq_empty ? '0 : r_cq_mem[r_cq_rp];
   assign cq_count      = r_cq_cnt;
   assign uc_valid      = |r_iq_cnt;
   assign uc_lit        = uc_valid ? r_iq_mem[r_iq_rp] : '0;
   assign conflict_flag = r_conflict;
   assign sat_cnt       = r_sat_cnt;

endmodule

// File: tb/tb_eng_p_queue.sv
// tb/tb_eng_p_queue.sv - self-checking bench for eng_p_queue

module tb_eng_p_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        ENG_P_push;
   logic [23:0] pr_clause;
   logic        imply;
   logic signed [7:0] imply_idx;
   logic        done;
   logic        conflict;
   logic        ENG_P_FULL;
   logic        cq_pop;
   logic        cq_empty;
   logic [23:0] cq_clause;
   logic [3:0]  cq_count;
   logic        uc_valid;
   logic [7:0]  uc_lit;
   logic        uc_ready;
   logic        conflict_flag;
   logic        conflict_clr;
   logic [15:0] sat_cnt;

   eng_p_queue dut (
      .clk           (clk),
      .rst           (rst),
      .ENG_P_push    (ENG_P_push),
      .pr_clause     (pr_clause),
      .imply         (imply),
      .imply_idx     (imply_idx),
      .done          (done),
      .conflict      (conflict),
      .ENG_P_FULL    (ENG_P_FULL),
      .cq_pop        (cq_pop),
      .cq_empty      (cq_empty),
      .cq_clause     (cq_clause),
      .cq_count      (cq_count),
      .uc_valid      (uc_valid),
      .uc_lit        (uc_lit),
      .uc_ready      (uc_ready),
      .conflict_flag (conflict_flag),
      .conflict_clr  (conflict_clr),
      .sat_cnt       (sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        p;
      logic [23:0] cls;
      logic        im;
      logic [7:0]  ix;
      logic        dn;
      logic        cf;
      logic        po;
      logic        rd;
      logic        clr;
      logic [3:0]  e_cnt;
      logic [23:0] e_cls;
      logic        e_uv;
      logic [7:0]  e_ul;
      logic        e_flag;
      logic [15:0] e_sat;
      logic        e_full;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;
   vec_t vt[$];
   logic [23:0] cq_m[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [23:0] cl(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic vec_t mkv(
      input logic p, input logic [23:0] c, input logic im, input logic [7:0] ix,
      input logic dn, input logic cf, input logic po, input logic rd, input logic clr,
      input logic [3:0] ecnt, input logic [23:0] ecl, input logic euv, input logic [7:0] eul,
      input logic efl, input logic [15:0] esat, input logic efull);
      vec_t v;
      v.p = p; v.cls = c; v.im = im; v.ix = ix; v.dn = dn; v.cf = cf;
      v.po = po; v.rd = rd; v.clr = clr;
      v.e_cnt = ecnt; v.e_cls = ecl; v.e_uv = euv; v.e_ul = eul;
      v.e_flag = efl; v.e_sat = esat; v.e_full = efull;
      return v;
   endfunction

   task automatic idle_inputs();
      ENG_P_push = 0; pr_clause = '0; imply = 0; imply_idx = '0; done = 0;
      conflict = 0; cq_pop = 0; uc_ready = 0; conflict_clr = 0;
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      ENG_P_push = v.p; pr_clause = v.cls; imply = v.im; imply_idx = v.ix;
      done = v.dn; conflict = v.cf; cq_pop = v.po; uc_ready = v.rd; conflict_clr = v.clr;
      @(posedge clk);
      #1;
      chk({tag, ".cnt"},   32'(cq_count),      32'(v.e_cnt));
      chk({tag, ".empty"}, 32'(cq_empty),      32'(v.e_cnt == 0));
      chk({tag, ".cls"},   32'(cq_clause),     32'(v.e_cls));
      chk({tag, ".uv"},    32'(uc_valid),      32'(v.e_uv));
      chk({tag, ".ul"},    32'(uc_lit),        32'(v.e_ul));
      chk({tag, ".flag"},  32'(conflict_flag), 32'(v.e_flag));
      chk({tag, ".sat"},   32'(sat_cnt),       32'(v.e_sat));
      chk({tag, ".full"},  32'(ENG_P_FULL),    32'(v.e_full));
   endtask

   // Plain-clause traffic checked against a reference queue; the model
   // decides acceptance from its own occupancy before the edge.
   task automatic step(input logic p, input logic [23:0] c, input logic po);
      logic acc;
      logic rd;
      @(negedge clk);
      acc = p && (cq_m.size() < 8);
      rd  = po && (cq_m.size() > 0);
      idle_inputs();
      ENG_P_push = p; pr_clause = c; cq_pop = po;
      if (rd) void'(cq_m.pop_front());
      if (acc) cq_m.push_back(c);
      @(posedge clk);
      #1;
      chk("sb.cnt",  32'(cq_count),   32'(cq_m.size()));
      chk("sb.head", 32'(cq_clause),  (cq_m.size() > 0) ? 32'(cq_m[0]) : 32'd0);
      chk("sb.full", 32'(ENG_P_FULL), 32'(cq_m.size() == 8));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".full"},  32'(ENG_P_FULL),    32'd0);
      chk({tag, ".empty"}, 32'(cq_empty),      32'd1);
      chk({tag, ".cnt"},   32'(cq_count),      32'd0);
      chk({tag, ".cls"},   32'(cq_clause),     32'd0);
      chk({tag, ".uv"},    32'(uc_valid),      32'd0);
      chk({tag, ".ul"},    32'(uc_lit),        32'd0);
      chk({tag, ".flag"},  32'(conflict_flag), 32'd0);
      chk({tag, ".sat"},   32'(sat_cnt),       32'd0);
   endtask

   initial begin
      // p  cls          im ix     dn cf po rd clr | cnt cls          uv ul     fl sat full
      vt.push_back(mkv(1, cl(1,4,5),  0, 8'd0,  0, 0, 0, 0, 0,  1, cl(1,4,5),  0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, cl(-1,2,3), 0, 8'd0,  0, 0, 0, 0, 0,  2, cl(1,4,5),  0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 1, 0, 0,  1, cl(-1,2,3), 0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 1, 0, 0,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd2,  0, 0, 0, 0, 0,  0, 0,          1, 8'd2,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd2,  0, 0, 0, 0, 0,  0, 0,          1, 8'd2,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd3,  0, 0, 0, 0, 0,  0, 0,          1, 8'd2,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          1, 8'd3,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd2,  0, 0, 0, 0, 0,  0, 0,          1, 8'd2,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'hFE, 0, 0, 0, 0, 0,  0, 0,          1, 8'd2,  1, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          0, 8'd0,  1, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 0, 1,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          0, 8'd0,  1, 1, 0, 0, 0,  0, 0,          0, 8'd0,  1, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 0, 1,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          0, 8'd0,  1, 0, 0, 0, 0,  0, 0,          0, 8'd0,  0, 1, 0));
      vt.push_back(mkv(1, 0,          0, 8'd0,  1, 0, 0, 0, 0,  0, 0,          0, 8'd0,  0, 2, 0));
      vt.push_back(mkv(1, 0,          0, 8'd0,  1, 0, 0, 0, 0,  0, 0,          0, 8'd0,  0, 3, 0));
      vt.push_back(mkv(1, cl(7,8,9),  0, 8'd0,  0, 0, 0, 0, 1,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          0, 8'd0,  0, 1, 0, 0, 1,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd0,  0, 0, 0, 0, 0,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd5,  1, 0, 0, 0, 0,  0, 0,          0, 8'd0,  0, 1, 0));
      vt.push_back(mkv(1, 0,          1, 8'd4,  0, 0, 0, 0, 0,  0, 0,          1, 8'd4,  0, 1, 0));
      vt.push_back(mkv(1, 0,          1, 8'd4,  0, 0, 0, 1, 0,  0, 0,          0, 8'd0,  0, 1, 0));
      vt.push_back(mkv(1, 0,          1, 8'd6,  0, 0, 0, 0, 0,  0, 0,          1, 8'd6,  0, 1, 0));
      vt.push_back(mkv(1, 0,          1, 8'hFA, 0, 0, 0, 1, 0,  0, 0,          0, 8'd0,  1, 1, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 0, 1,  0, 0,          0, 8'd0,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd1,  0, 0, 0, 0, 0,  0, 0,          1, 8'd1,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd2,  0, 0, 0, 0, 0,  0, 0,          1, 8'd1,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd3,  0, 0, 0, 0, 0,  0, 0,          1, 8'd1,  0, 0, 0));
      vt.push_back(mkv(1, 0,          1, 8'd4,  0, 0, 0, 0, 0,  0, 0,          1, 8'd1,  0, 0, 1));
      vt.push_back(mkv(1, cl(1,1,1),  0, 8'd0,  0, 0, 0, 0, 0,  0, 0,          1, 8'd1,  0, 0, 1));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          1, 8'd2,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          1, 8'd3,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          1, 8'd4,  0, 0, 0));
      vt.push_back(mkv(0, 0,          0, 8'd0,  0, 0, 0, 1, 0,  0, 0,          0, 8'd0,  0, 0, 0));

      idle_inputs();
      rst = 1'b1;
      #3;
      check_reset("rst0");
      @(negedge clk);
      rst = 1'b0;

      foreach (vt[k]) apply(vt[k], $sformatf("v%0d", k));

      // Fill the clause FIFO, overflow attempt, push+pop while full, drain.
      for (int i = 0; i < 8; i++) step(1'b1, cl(20 + i, i, -i), 1'b0);
      step(1'b1, cl(99, 99, 99), 1'b0);
      step(1'b1, cl(98, 98, 98), 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

      // Asynchronous reset with clauses, a count and an implication held.
      for (int i = 0; i < 5; i++) step(1'b1, cl(40 + i, 1, 2), 1'b0);
      apply(mkv(1, 0, 0, 8'd0, 1, 0, 0, 0, 0, 5, cq_m[0], 0, 8'd0, 0, 1, 0), "pre_rst_a");
      apply(mkv(1, 0, 1, 8'd9, 0, 0, 0, 0, 0, 5, cq_m[0], 1, 8'd9, 0, 1, 0), "pre_rst_b");
      @(negedge clk);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      check_reset("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      cq_m.delete();

      // Random plain-clause traffic with wraparound and full cycles.
      for (int i = 0; i < 80; i++) begin
         step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 2) == 0);
      end

      @(negedge clk);
      idle_inputs();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
